// File: rtl/regfile_sb_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_sb_if : read, issue, write-back and flush bundle for regfile_sb  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(NREGS + 1);

  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            issue_ready;
  logic            wb0_en;
  logic [AW-1:0]   wb0_rd;
  logic [XLEN-1:0] wb0_data;
  logic            wb1_en;
  logic [AW-1:0]   wb1_rd;
  logic [XLEN-1:0] wb1_data;
  logic            flush;
  logic [CW-1:0]   busy_count;

  modport master (
    output rs1_addr, rs2_addr, issue_valid, issue_rd,
    output wb0_en, wb0_rd, wb0_data, wb1_en, wb1_rd, wb1_data, flush,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, issue_ready, busy_count
  );

  modport slave (
    input  rs1_addr, rs2_addr, issue_valid, issue_rd,
    input  wb0_en, wb0_rd, wb0_data, wb1_en, wb1_rd, wb1_data, flush,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, issue_ready, busy_count
  );
endinterface
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_sb : dual write-back register file with busy scoreboard.         |
// | Optional RF_BYPASS_EN forwards same-cycle write data to the read ports.  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module regfile_sb #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS),
  localparam int CW    = $clog2(NREGS + 1)
) (
  input  logic           clk,
  input  logic           rst,
  regfile_sb_if.slave    rf
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;

  logic wb0_act;
  logic wb1_act;
  logic clr0;
  logic clr1;
  logic issue_set;

  assign wb0_act   = rf.wb0_en && (rf.wb0_rd != '0);
  assign wb1_act   = rf.wb1_en && (rf.wb1_rd != '0);
  // A busy index hit by both ports is released only once
  assign clr0      = wb0_act && busy[rf.wb0_rd];
  assign clr1      = wb1_act && busy[rf.wb1_rd] && !(wb0_act && (rf.wb1_rd == rf.wb0_rd));

  assign rf.issue_ready = rf.issue_valid && !rf.flush &&
                          ((rf.issue_rd == '0) || !busy[rf.issue_rd]);
  assign issue_set      = rf.issue_ready && (rf.issue_rd != '0);

  always_comb begin
    busy_nxt = busy;
    if (wb0_act)   busy_nxt[rf.wb0_rd]   = 1'b0;
    if (wb1_act)   busy_nxt[rf.wb1_rd]   = 1'b0;
    if (issue_set) busy_nxt[rf.issue_rd] = 1'b1;
    if (rf.flush)  busy_nxt = '0;
  end

  always_comb begin
    count_nxt = count + CW'(issue_set) - CW'(clr0) - CW'(clr1);
    if (rf.flush) count_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy  <= '0;
      count <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      busy  <= busy_nxt;
      count <= count_nxt;
      // wb1 first so that wb0 wins on a shared index
      if (wb1_act) regs[rf.wb1_rd] <= rf.wb1_data;
      if (wb0_act) regs[rf.wb0_rd] <= rf.wb0_data;
    end
  end

  assign rf.busy_count = count;

  always_comb begin
    rf.rs1_data = (rf.rs1_addr == '0) ? '0 : regs[rf.rs1_addr];
    rf.rs1_busy = busy[rf.rs1_addr];
    rf.rs2_data = (rf.rs2_addr == '0) ? '0 : regs[rf.rs2_addr];
    rf.rs2_busy = busy[rf.rs2_addr];
`ifdef RF_BYPASS_EN
    if (wb0_act && (rf.wb0_rd == rf.rs1_addr)) begin
      rf.rs1_data = rf.wb0_data;
      rf.rs1_busy = 1'b0;
    end else if (wb1_act && (rf.wb1_rd == rf.rs1_addr)) begin
      rf.rs1_data = rf.wb1_data;
      rf.rs1_busy = 1'b0;
    end
    if (wb0_act && (rf.wb0_rd == rf.rs2_addr)) begin
      rf.rs2_data = rf.wb0_data;
      rf.rs2_busy = 1'b0;
    end else if (wb1_act && (rf.wb1_rd == rf.rs2_addr)) begin
      rf.rs2_data = rf.wb1_data;
      rf.rs2_busy = 1'b0;
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_sb : directed and random stimulus against a scoreboard model. |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_regfile_sb;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0]  rs1_addr, rs2_addr, issue_rd, wb0_rd, wb1_rd;
  logic [31:0] wb0_data, wb1_data;
  logic        issue_valid, wb0_en, wb1_en, flush;

  regfile_sb_if #(.XLEN(32), .NREGS(32)) rf ();

  assign rf.rs1_addr    = rs1_addr;
  assign rf.rs2_addr    = rs2_addr;
  assign rf.issue_valid = issue_valid;
  assign rf.issue_rd    = issue_rd;
  assign rf.wb0_en      = wb0_en;
  assign rf.wb0_rd      = wb0_rd;
  assign rf.wb0_data    = wb0_data;
  assign rf.wb1_en      = wb1_en;
  assign rf.wb1_rd      = wb1_rd;
  assign rf.wb1_data    = wb1_data;
  assign rf.flush       = flush;

  regfile_sb #(.XLEN(32), .NREGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf)
  );

  logic [31:0] m_regs [32];
  bit          m_busy [32];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (BYP && wb0_en && wb0_rd == a) return wb0_data;
    if (BYP && wb1_en && wb1_rd == a) return wb1_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (BYP && ((wb0_en && wb0_rd == a) || (wb1_en && wb1_rd == a))) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_ready();
    return issue_valid && !flush && (issue_rd == 0 || !m_busy[issue_rd]);
  endfunction

  function automatic int popcount();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic acc;
    if (!rst) begin
      model_reset();
    end else begin
      acc = exp_ready();
      if (wb1_en && wb1_rd != 0) begin m_regs[wb1_rd] = wb1_data; m_busy[wb1_rd] = 1'b0; end
      if (wb0_en && wb0_rd != 0) begin m_regs[wb0_rd] = wb0_data; m_busy[wb0_rd] = 1'b0; end
      if (acc && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      if (flush) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    rst = 1'b1; flush = 1'b0;
    rs1_addr = '0; rs2_addr = '0;
    issue_valid = 1'b0; issue_rd = '0;
    wb0_en = 1'b0; wb0_rd = '0; wb0_data = '0;
    wb1_en = 1'b0; wb1_rd = '0; wb1_data = '0;
  endtask

  // Compare all outputs against the model, then advance one clock
  task automatic step();
    #1;
    check("rs1_data", rf.rs1_data, exp_data(rs1_addr));
    check("rs2_data", rf.rs2_data, exp_data(rs2_addr));
    check("rs1_busy", rf.rs1_busy, exp_busy(rs1_addr));
    check("rs2_busy", rf.rs2_busy, exp_busy(rs2_addr));
    check("issue_ready", rf.issue_ready, exp_ready());
    check("busy_count", rf.busy_count, popcount());
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    model_reset();

    // Reset clears earlier writes
    idle(); wb0_en = 1; wb0_rd = 5; wb0_data = 32'h1234; step();
    idle(); rst = 1'b0; step(); step();
    idle(); rs1_addr = 5; #1;
    check("rst_r5_data", rf.rs1_data, 32'h0);
    check("rst_r5_busy", rf.rs1_busy, 1'b0);
    check("rst_count", rf.busy_count, 0);
    step();

    // RAW on r7
    idle(); issue_valid = 1; issue_rd = 7; rs1_addr = 7; step();
    idle(); rs1_addr = 7; wb0_en = 1; wb0_rd = 7; wb0_data = 32'hDEADBEEF; #1;
    check("raw_busy_wb_cycle", rf.rs1_busy, BYP ? 1'b0 : 1'b1);
    check("raw_data_wb_cycle", rf.rs1_data, BYP ? 32'hDEADBEEF : 32'h0);
    check("raw_count_before", rf.busy_count, 1);
    step();
    idle(); rs1_addr = 7; #1;
    check("raw_data_after", rf.rs1_data, 32'hDEADBEEF);
    check("raw_count_after", rf.busy_count, 0);
    step();

    // Dual write-back
    idle(); wb0_en = 1; wb0_rd = 3; wb0_data = 32'h11; wb1_en = 1; wb1_rd = 3; wb1_data = 32'h22; step();
    idle(); rs1_addr = 3; #1; check("dual_same_idx", rf.rs1_data, 32'h11); step();
    idle(); issue_valid = 1; issue_rd = 4; step();
    idle(); issue_valid = 1; issue_rd = 9; step();
    idle(); #1; check("dual_count_before", rf.busy_count, 2);
    wb0_en = 1; wb0_rd = 4; wb0_data = 32'h44; wb1_en = 1; wb1_rd = 9; wb1_data = 32'h99; step();
    idle(); #1; check("dual_count_after", rf.busy_count, 0); step();

    // WAW stall and r0 behaviour
    idle(); issue_valid = 1; issue_rd = 4; step();
    idle(); issue_valid = 1; issue_rd = 4; #1; check("waw_ready", rf.issue_ready, 1'b0); step();
    idle(); issue_valid = 1; issue_rd = 0; #1;
    check("waw_count", rf.busy_count, 1);
    check("r0_ready", rf.issue_ready, 1'b1);
    step();
    idle(); wb0_en = 1; wb0_rd = 0; wb0_data = 32'hFF; #1; check("r0_count", rf.busy_count, 1); step();
    idle(); rs1_addr = 0; #1; check("r0_data", rf.rs1_data, 32'h0); step();
    idle(); wb0_en = 1; wb0_rd = 4; wb0_data = 32'h4; step();

    // Flush with concurrent write-back and issue
    for (int r = 1; r <= 3; r++) begin
      idle(); issue_valid = 1; issue_rd = 5'(r); step();
    end
    idle(); #1; check("flush_count_before", rf.busy_count, 3);
    flush = 1; wb1_en = 1; wb1_rd = 2; wb1_data = 32'h55; issue_valid = 1; issue_rd = 6; #1;
    check("flush_ready", rf.issue_ready, 1'b0);
    step();
    idle(); rs1_addr = 2; rs2_addr = 6; #1;
    check("flush_r2_data", rf.rs1_data, 32'h55);
    check("flush_r6_busy", rf.rs2_busy, 1'b0);
    check("flush_count_after", rf.busy_count, 0);
    step();

    // Reset mid-operation
    idle(); wb0_en = 1; wb0_rd = 9; wb0_data = 32'h77; step();
    idle(); rst = 1'b0; issue_valid = 1; issue_rd = 8; wb0_en = 1; wb0_rd = 9; wb0_data = 32'h1; step();
    idle(); rs1_addr = 8; rs2_addr = 9; #1;
    check("mrst_r8_busy", rf.rs1_busy, 1'b0);
    check("mrst_r9_data", rf.rs2_data, 32'h0);
    check("mrst_count", rf.busy_count, 0);
    step();

    // Randomized traffic on a small index window to provoke hazards
    for (int i = 0; i < 600; i++) begin
      idle();
      rst         = ($urandom_range(0, 63) != 0);
      flush       = ($urandom_range(0, 19) == 0);
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom_range(0, 9));
      wb0_en      = 1'($urandom_range(0, 1));
      wb0_rd      = 5'($urandom_range(0, 9));
      wb0_data    = $urandom;
      wb1_en      = 1'($urandom_range(0, 1));
      wb1_rd      = ($urandom_range(0, 3) == 0) ? wb0_rd : 5'($urandom_range(0, 9));
      wb1_data    = $urandom;
      rs1_addr    = ($urandom_range(0, 3) == 0) ? wb0_rd : 5'($urandom_range(0, 9));
      rs2_addr    = ($urandom_range(0, 3) == 0) ? wb1_rd : 5'($urandom_range(0, 31));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the single-write register file: configurable width/depth, two write-back ports, per-register busy (scoreboard) bits and an outstanding-write counter.
Sits in the pipelined core between decode (issue/read) and the ALU and load write-back stages.
Decode uses the busy flags to stall on RAW/WAW hazards.
Register 0 is hard-wired to zero.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of registers (power of two, 4..64)
AW, $clog2(NREGS), register index width (derived; do not override)
CW, $clog2(NREGS+1), busy_count width (derived)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-low reset (sampled on posedge clk)
rs1_addr  in  AW  read port 1 index
rs2_addr  in  AW  read port 2 index
rs1_data  out  XLEN  read port 1 data
rs2_data  out  XLEN  read port 2 data
rs1_busy  out  1  busy bit of rs1_addr
rs2_busy  out  1  busy bit of rs2_addr
issue_valid  in  1  decode requests allocation of issue_rd
issue_rd  in  AW  destination being issued
issue_ready  out  1  allocation accepted this cycle
wb0_en  in  1  ALU write-back enable
wb0_rd  in  AW  ALU write-back index
wb0_data  in  XLEN  ALU write-back data
wb1_en  in  1  load write-back enable
wb1_rd  in  AW  load write-back index
wb1_data  in  XLEN  load write-back data
flush  in  1  clear all busy bits (pipeline flush)
busy_count  out  CW  number of registers currently busy

Behaviour:
- Reset (rst==0 at posedge): all registers = 0; all busy bits = 0; busy_count = 0. Reset has priority over every other input. Mid-operation reset discards pending writes and issues that cycle.
- Reads are combinational from the register array.
  - Without bypass, a write is visible on rs*_data the cycle after its posedge.
  - Index 0 always reads 0 and is never busy.
- rs*_busy are combinational from the busy array (current state).
- Writes (posedge):
  - wbN_en && wbN_rd!=0 -> reg[wbN_rd] <= wbN_data and busy[wbN_rd] <= 0.
  - wb0 and wb1 to the same index in one cycle -> wb0 data wins; busy cleared.
  - A write to a non-busy register is legal: data is written, busy stays 0.
- Issue:
  - issue_ready = issue_valid && !flush && (issue_rd==0 || !busy[issue_rd]), combinational.
  - Accepted with issue_rd!=0 -> busy[issue_rd] <= 1.
  - Issue to rd==0 -> ready, no state change.
- Simultaneous issue and write-back, same rd:
  - Allowed only if that rd was not busy, i.e. a stray write to a free register.
  - Busy ends set and the data is written.
- Flush (posedge, flush==1):
  - All busy bits <= 0; busy_count <= 0.
  - Same-cycle wb data writes still commit.
  - Issues are rejected (issue_ready=0).
- busy_count is registered and always equals popcount(busy) after each edge.
  - Updated incrementally: +1 per accepted issue to rd!=0; -1 per distinct busy index cleared by write-back (max -2 per cycle; two ports on the same index count once).
  - Never wraps: range 0..NREGS-1.
- No X propagation: unused read indices >= NREGS cannot occur (power-of-two depth).

Optional Feature:
RF_BYPASS_EN.
- Defined: write-through forwarding on read ports. If wb0 (or wb1) is enabled to rsN_addr!=0 in the current cycle, rsN_data returns that write data (wb0 priority), and rsN_busy reads 0 in that cycle.
- Undefined: reads return array contents only; same-cycle write data is not forwarded, and busy reflects pre-edge state.

Test Plan:
- Reset: hold rst=0 two cycles after writes to r5 -> rs1_data(r5)=0, rs1_busy=0, busy_count=0.
- Issue r7; next cycle wb0 r7=0xDEADBEEF -> rs1_busy=1 between, then rs1_data=0xDEADBEEF, busy=0, busy_count 1->0. With RF_BYPASS_EN, rs1_data=0xDEADBEEF in the wb cycle itself.
- Dual write-back: wb0 r3=0x11, wb1 r3=0x22 same cycle -> r3=0x11. wb0 r4, wb1 r9, both busy -> busy_count drops by 2.
- WAW stall: issue r4, then issue r4 again -> issue_ready=0, busy_count stays 1. Issue r0 -> ready=1, busy_count unchanged. wb0 to r0=0xFF -> r0 reads 0.
- Flush: issue r1,r2,r3 (busy_count=3); flush with wb1 r2=0x55 and issue r6 -> busy_count=0, r2=0x55, issue_ready=0, r6 not busy.
- Reset mid-operation: rst=0 in the same cycle as issue r8 and wb0 r9=0x1 -> r8 not busy, r9=0, busy_count=0.
